max_pool_2x2: RTL and testbench

Streaming 2×2 stride-2 max-pooling stage directly downstream of the max-pooling control/convolution stage. It consumes that stage's raster-ordered Q4.6 result stream (`out_px_o`/`px_rdy_o`). It emits one pooled Q4.6 pixel per 2×2 input block, using a half-row line buffer instead of a full frame store. Output is a raster stream of (IMG_WIDTH/2)×(IMG_HEIGHT/2) pixels plus an end-of-frame pulse.

---
 rtl/max_pool_2x2_pkg.sv | 22 ++
 rtl/pool_line_buffer.sv | 41 ++++
 rtl/max_pool_2x2.sv | 174 +++++++++++++++++
 tb/tb_max_pool_2x2.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/max_pool_2x2_pkg.sv
// -----------------------------------------------------------------------------
// max_pool_2x2_pkg
// Shared constants and types for the 2x2 max-pooling stage.
//   BITS_Q4_6            : width of a signed Q4.6 sample
//   MAX_RESOLUTION_BITS  : bit width of the largest supported input resolution
//   POOL_RESOLUTION_BITS : the same width after 2x decimation
//   q4_6_t               : signed Q4.6 sample type
//   ST_*                 : pooling FSM state encodings
// -----------------------------------------------------------------------------
package max_pool_2x2_pkg;

  localparam int BITS_Q4_6            = 10;
  localparam int MAX_RESOLUTION_BITS  = 10;
  localparam int POOL_RESOLUTION_BITS = MAX_RESOLUTION_BITS - 1;

  typedef logic signed [BITS_Q4_6-1:0] q4_6_t;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_EVEN_ROW = 2'd1;
  localparam logic [1:0] ST_ODD_ROW  = 2'd2;

endpackage

// File: rtl/pool_line_buffer.sv
// -----------------------------------------------------------------------------
// pool_line_buffer
// Half-row storage for the pooling stage: one entry per horizontal pixel pair,
// holding the max of the upper row of each 2x2 block until the lower row
// arrives. Contents are deliberately not reset; every entry is written in an
// even row before it is read in the following odd row.
// Ports:
//   clk_i   : clock
//   wr_en   : write strobe (synchronous)
//   wr_addr : write entry index
//   wr_data : value to store
//   rd_addr : read entry index
//   rd_data : stored value at rd_addr (combinational read)
// -----------------------------------------------------------------------------
module pool_line_buffer
  import max_pool_2x2_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = BITS_Q4_6,
  parameter int ADDR_W = 2
) (
  input  logic              clk_i,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Synchronous write port
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/max_pool_2x2.sv
// -----------------------------------------------------------------------------
// max_pool_2x2
// Streaming 2x2 stride-2 max pooling over a raster-ordered Q4.6 pixel stream.
// Even rows fold each horizontal pair into a half-row line buffer; odd rows
// fold the buffered value with the lower pair and emit one pooled pixel per
// block. Unpaired trailing columns/rows are consumed without producing output.
// Ports:
//   clk_i        : clock, rising edge
//   nreset_i     : asynchronous active-low reset
//   start_i      : frame enable level; low aborts the frame and returns to IDLE
//   px_rdy_i     : input sample strobe
//   in_px_i      : signed Q4.6 input sample
//   out_px_o     : pooled sample, held between updates
//   px_rdy_o     : one-cycle strobe when out_px_o is new
//   frame_done_o : one-cycle strobe alongside the last pooled pixel of a frame
// -----------------------------------------------------------------------------
module max_pool_2x2
  import max_pool_2x2_pkg::*;
#(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int DATA_W     = BITS_Q4_6
) (
  input  logic              clk_i,
  input  logic              nreset_i,
  input  logic              start_i,
  input  logic              px_rdy_i,
  input  logic [DATA_W-1:0] in_px_i,
  output logic [DATA_W-1:0] out_px_o,
  output logic              px_rdy_o,
  output logic              frame_done_o
);

  localparam int COL_W     = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int BUF_DEPTH = IMG_WIDTH / 2;
  localparam int BUF_AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  localparam logic [COL_W-1:0] LAST_COL      = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW      = ROW_W'(IMG_HEIGHT - 1);
  // Last column/row that belongs to a complete 2x2 block (odd sizes drop one)
  localparam logic [COL_W-1:0] LAST_PAIR_COL = COL_W'((IMG_WIDTH / 2) * 2 - 1);
  localparam logic [ROW_W-1:0] LAST_PAIR_ROW = ROW_W'((IMG_HEIGHT / 2) * 2 - 1);

  logic [1:0]              state_r;
  logic [COL_W-1:0]        col_cnt_r;
  logic [ROW_W-1:0]        row_cnt_r;
  logic signed [DATA_W-1:0] hold_r;

  logic                     even_s;
  logic                     odd_s;
  logic                     accept_s;
  logic                     col_odd_s;
  logic                     pair_col_s;
  logic                     pair_row_s;
  logic                     buf_we_s;
  logic                     hold_top_s;
  logic                     hold_bot_s;
  logic                     emit_s;
  logic                     last_block_s;
  logic                     end_of_row_s;
  logic                     end_of_frame_s;
  logic [BUF_AW-1:0]        pair_idx_s;
  logic [DATA_W-1:0]        buf_rdata_s;
  logic signed [DATA_W-1:0] upper_max_s;
  logic signed [DATA_W-1:0] lower_max_s;

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a >= b) ? a : b;
  endfunction

  // Decode the current sample's role within its 2x2 block
  always_comb begin
    even_s         = (state_r == ST_EVEN_ROW);
    odd_s          = (state_r == ST_ODD_ROW);
    // An abort in the same cycle as a strobe drops the sample
    accept_s       = start_i && px_rdy_i && (even_s || odd_s);
    col_odd_s      = col_cnt_r[0];
    pair_col_s     = (col_cnt_r <= LAST_PAIR_COL);
    pair_row_s     = (row_cnt_r <= LAST_PAIR_ROW);
    buf_we_s       = accept_s && even_s && col_odd_s && pair_col_s && pair_row_s;
    hold_top_s     = accept_s && even_s && !col_odd_s && pair_col_s && pair_row_s;
    hold_bot_s     = accept_s && odd_s && !col_odd_s && pair_col_s;
    emit_s         = accept_s && odd_s && col_odd_s && pair_col_s;
    last_block_s   = emit_s && (row_cnt_r == LAST_PAIR_ROW) && (col_cnt_r == LAST_PAIR_COL);
    end_of_row_s   = (col_cnt_r == LAST_COL);
    end_of_frame_s = (row_cnt_r == LAST_ROW);
    pair_idx_s     = BUF_AW'(col_cnt_r >> 1);
    upper_max_s    = smax(hold_r, $signed(in_px_i));
    lower_max_s    = smax($signed(buf_rdata_s), $signed(in_px_i));
  end

  // Write and read share one index: writes happen in even rows, reads in odd rows
  pool_line_buffer #(
    .DEPTH  (BUF_DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (BUF_AW)
  ) u_line_buffer (
    .clk_i   (clk_i),
    .wr_en   (buf_we_s),
    .wr_addr (pair_idx_s),
    .wr_data (upper_max_s),
    .rd_addr (pair_idx_s),
    .rd_data (buf_rdata_s)
  );

  // Datapath: partial-max register and registered outputs
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      hold_r       <= '0;
      out_px_o     <= '0;
      px_rdy_o     <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      px_rdy_o     <= emit_s;
      frame_done_o <= last_block_s;
      if (emit_s) begin
        out_px_o <= upper_max_s;
      end
      if (hold_top_s) begin
        hold_r <= $signed(in_px_i);
      end else if (hold_bot_s) begin
        hold_r <= lower_max_s;
      end
    end
  end

  // Control: row-parity FSM with column/row position counters
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_r   <= ST_IDLE;
      col_cnt_r <= '0;
      row_cnt_r <= '0;
    end else if (!start_i) begin
      state_r   <= ST_IDLE;
      col_cnt_r <= '0;
      row_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r   <= ST_EVEN_ROW;
          col_cnt_r <= '0;
          row_cnt_r <= '0;
        end
        ST_EVEN_ROW, ST_ODD_ROW: begin
          if (px_rdy_i) begin
            if (end_of_row_s) begin
              col_cnt_r <= '0;
              if (end_of_frame_s) begin
                // Covers both the last odd row and a trailing unpaired row
                row_cnt_r <= '0;
                state_r   <= ST_IDLE;
              end else begin
                row_cnt_r <= row_cnt_r + ROW_W'(1'b1);
                state_r   <= even_s ? ST_ODD_ROW : ST_EVEN_ROW;
              end
            end else begin
              col_cnt_r <= col_cnt_r + COL_W'(1'b1);
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          col_cnt_r <= '0;
          row_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max_pool_2x2.sv
// -----------------------------------------------------------------------------
// tb_max_pool_2x2
// Self-checking bench for max_pool_2x2: a 4x4 and a 5x5 instance driven with
// directed and randomized frames, compared against a block-max reference model.
// -----------------------------------------------------------------------------
module tb_max_pool_2x2;
  import max_pool_2x2_pkg::*;

  logic       clk = 1'b0;
  logic       nreset;
  logic       start_a, rdy_a, start_b, rdy_b;
  logic [9:0] px_a, px_b;
  logic [9:0] out_a, out_b;
  logic       ordy_a, ordy_b, fd_a, fd_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int cur_sel  = 0;

  logic [9:0] frame_px [0:24];
  int obs_px[$];
  int obs_cyc[$];
  int obs_fd[$];
  int obs_rdy[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  max_pool_2x2 #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .DATA_W(BITS_Q4_6)) dut_a (
    .clk_i(clk), .nreset_i(nreset), .start_i(start_a), .px_rdy_i(rdy_a),
    .in_px_i(px_a), .out_px_o(out_a), .px_rdy_o(ordy_a), .frame_done_o(fd_a));

  max_pool_2x2 #(.IMG_WIDTH(5), .IMG_HEIGHT(5), .DATA_W(BITS_Q4_6)) dut_b (
    .clk_i(clk), .nreset_i(nreset), .start_i(start_b), .px_rdy_i(rdy_b),
    .in_px_i(px_b), .out_px_o(out_b), .px_rdy_o(ordy_b), .frame_done_o(fd_b));

  // Record every output event of the instance under test, away from the active edge
  always @(negedge clk) begin
    if (cur_sel == 0 && (ordy_a || fd_a)) begin
      obs_px.push_back(int'(out_a)); obs_cyc.push_back(cyc);
      obs_fd.push_back(int'(fd_a));  obs_rdy.push_back(int'(ordy_a));
    end else if (cur_sel == 1 && (ordy_b || fd_b)) begin
      obs_px.push_back(int'(out_b)); obs_cyc.push_back(cyc);
      obs_fd.push_back(int'(fd_b));  obs_rdy.push_back(int'(ordy_b));
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rdy, input logic [9:0] px);
    if (sel == 0) begin rdy_a = rdy; px_a = px; end
    else          begin rdy_b = rdy; px_b = px; end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start_a = v;
    else          start_b = v;
  endtask

  task automatic fill_ramp(input int n);
    for (int i = 0; i < n; i++) frame_px[i] = 10'(i);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 7))
        0:       frame_px[i] = 10'h200;
        1:       frame_px[i] = 10'h1FF;
        2:       frame_px[i] = (i > 0) ? frame_px[i-1] : 10'h3FF;
        default: frame_px[i] = 10'($urandom_range(0, 1023));
      endcase
    end
  endtask

  // Drive one frame from frame_px; abort_at >= 0 drops start_i together with that sample
  task automatic run_frame(input int sel, input int w, input int h,
                           input int max_gap, input int abort_at);
    int exp_px[$];
    int exp_cyc[$];
    int m, n, sv;
    q4_6_t v;
    obs_px.delete(); obs_cyc.delete(); obs_fd.delete(); obs_rdy.delete();
    cur_sel = sel;
    // Reference: signed maximum of every complete 2x2 block, block raster order
    for (int br = 0; br < h / 2; br++) begin
      for (int bc = 0; bc < w / 2 && bc < (1 << POOL_RESOLUTION_BITS); bc++) begin
        m = -100000;
        for (int d = 0; d < 4; d++) begin
          v  = frame_px[(2 * br + d / 2) * w + 2 * bc + d % 2];
          sv = int'(v);
          if (sv > m) m = sv;
        end
        exp_px.push_back(m & 32'h3FF);
      end
    end
    set_start(sel, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < w * h; i++) begin
      int r = i / w;
      int c = i % w;
      if (i == abort_at) set_start(sel, 1'b0);
      drive(sel, 1'b1, frame_px[i]);
      if (abort_at < 0 && r % 2 == 1 && c % 2 == 1 && r < (h / 2) * 2 && c < (w / 2) * 2)
        exp_cyc.push_back(cyc + 1);
      @(posedge clk);
      #1;
      drive(sel, 1'b0, 10'h000);
      if (i == abort_at) break;
      n = $urandom_range(0, max_gap);
      repeat (n) begin @(posedge clk); #1; end
    end
    repeat (4) @(posedge clk);
    #1;
    set_start(sel, 1'b0);
    @(posedge clk);
    #1;
    if (abort_at >= 0) begin
      check_eq("abort_no_output", obs_px.size(), 0);
    end else begin
      check_eq("out_count", obs_px.size(), exp_px.size());
      for (int i = 0; i < obs_px.size() && i < exp_px.size(); i++) begin
        check_eq("out_px", obs_px[i], exp_px[i]);
        check_eq("out_latency", obs_cyc[i], exp_cyc[i]);
        check_eq("px_rdy_o", obs_rdy[i], 1);
        check_eq("frame_done", obs_fd[i], (i == exp_px.size() - 1) ? 1 : 0);
      end
    end
  endtask

  initial begin
    nreset = 1'b0;
    start_a = 1'b0; rdy_a = 1'b0; px_a = 10'h000;
    start_b = 1'b0; rdy_b = 1'b0; px_b = 10'h000;
    #2;
    // Reset values applied asynchronously, before any clock edge
    check_eq("rst_out_a", int'(out_a), 0);
    check_eq("rst_rdy_a", int'(ordy_a), 0);
    check_eq("rst_fd_a",  int'(fd_a), 0);
    check_eq("rst_out_b", int'(out_b), 0);
    check_eq("rst_rdy_b", int'(ordy_b), 0);
    check_eq("rst_fd_b",  int'(fd_b), 0);
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
    @(posedge clk);
    #1;

    // Basic 4x4 ramp, back-to-back
    fill_ramp(16);
    run_frame(0, 4, 4, 0, -1);
    if (obs_px.size() == 4) begin
      check_eq("basic_px0", obs_px[0], 10'h005);
      check_eq("basic_px3", obs_px[3], 10'h00F);
    end

    // Signed comparison blocks
    fill_random(16);
    frame_px[0] = 10'h3C0; frame_px[1] = 10'h3FF; frame_px[2] = 10'h3C0; frame_px[3] = 10'h040;
    frame_px[4] = 10'h380; frame_px[5] = 10'h200; frame_px[6] = 10'h3FF; frame_px[7] = 10'h000;
    run_frame(0, 4, 4, 0, -1);
    if (obs_px.size() >= 2) begin
      check_eq("signed_blk0", obs_px[0], 10'h3FF);
      check_eq("signed_blk1", obs_px[1], 10'h040);
    end

    // Gapped strobes
    fill_ramp(16);
    run_frame(0, 4, 4, 3, -1);

    // Abort coinciding with the sixth sample, then a full frame
    run_frame(0, 4, 4, 0, 5);
    run_frame(0, 4, 4, 1, -1);

    // Odd dimensions 5x5
    fill_ramp(25);
    run_frame(1, 5, 5, 0, -1);
    if (obs_px.size() == 4) begin
      check_eq("odd_px0", obs_px[0], 6);
      check_eq("odd_px3", obs_px[3], 18);
    end

    // Randomized frames on both geometries
    for (int k = 0; k < 6; k++) begin
      fill_random(25);
      if (k % 2 == 0) run_frame(0, 4, 4, k % 4, -1);
      else            run_frame(1, 5, 5, k % 4, -1);
    end

    // Async reset in the middle of an odd row
    fill_ramp(16);
    cur_sel = 0;
    start_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      drive(0, 1'b1, frame_px[i]);
      @(posedge clk);
      #1;
    end
    drive(0, 1'b0, 10'h000);
    #2;
    check_eq("pre_reset_out", int'(out_a), 10'h005);
    nreset = 1'b0;
    #1;
    check_eq("areset_out", int'(out_a), 0);
    check_eq("areset_rdy", int'(ordy_a), 0);
    check_eq("areset_fd",  int'(fd_a), 0);
    start_a = 1'b0;
    @(posedge clk);
    #1;
    nreset = 1'b1;
    @(posedge clk);
    #1;
    run_frame(0, 4, 4, 2, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
